// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU op + operands behind a
// main+skid valid/ready buffer. Define ALU_ISSUE_ILLEGAL_EN to expose the out_illegal flag.
module alu_issue_stage #(
  parameter int unsigned N_BITS   = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [N_BITS-1:0]   in_pc,
  input  logic [N_BITS-1:0]   in_rs1_data,
  input  logic [N_BITS-1:0]   in_rs2_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [N_BITS-1:0]   out_in0,
  output logic [N_BITS-1:0]   out_in1,
  output logic [4:0]          out_rd,
  output logic                out_we
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic                out_illegal
`endif
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  typedef struct packed {
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                illegal;
`endif
    logic                we;
    logic [4:0]          rd;
    logic [ALU_OP_W-1:0] op;
    logic [N_BITS-1:0]   in0;
    logic [N_BITS-1:0]   in1;
  } payload_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [N_BITS-1:0] imm_i;
  logic [N_BITS-1:0] imm_u;
  logic [N_BITS-1:0] shamt;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(N_BITS-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = N_BITS'({in_instr[31:12], 12'b0});
  assign shamt  = N_BITS'(in_instr[24:20]);

  logic              legal;
  logic [2:0]        dec_aop;
  logic              dec_aux;
  logic [N_BITS-1:0] dec_in0;
  logic [N_BITS-1:0] dec_in1;
  payload_t          dec;

  always_comb begin
    legal   = 1'b0;
    dec_aop = 3'b000;
    dec_aux = 1'b0;
    dec_in0 = '0;
    dec_in1 = '0;
    case (opcode)
      OpcOp: begin
        legal   = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_aop = funct3;
        dec_aux = ((funct3 == 3'b000) || (funct3 == 3'b101)) && in_instr[30];
        dec_in0 = in_rs1_data;
        dec_in1 = in_rs2_data;
      end
      OpcOpImm: begin
        dec_aop = funct3;
        dec_in0 = in_rs1_data;
        if (funct3 == 3'b001) begin
          legal   = (funct7 == 7'h00);
          dec_in1 = shamt;
        end else if (funct3 == 3'b101) begin
          legal   = (funct7 == 7'h00) || (funct7 == 7'h20);
          dec_aux = in_instr[30];
          dec_in1 = shamt;
        end else begin
          // ADDI must never become SUB even when imm[10] is set
          legal   = 1'b1;
          dec_in1 = imm_i;
        end
      end
      OpcLui: begin
        legal   = 1'b1;
        dec_in1 = imm_u;
      end
      OpcAuipc: begin
        legal   = 1'b1;
        dec_in0 = in_pc;
        dec_in1 = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries issue as a NOP with no register write.
  always_comb begin
    dec = '0;
    if (legal) begin
      dec.op  = ALU_OP_W'({dec_aop, dec_aux});
      dec.in0 = dec_in0;
      dec.in1 = dec_in1;
      dec.rd  = rd;
      dec.we  = (rd != 5'd0);
    end
`ifdef ALU_ISSUE_ILLEGAL_EN
    dec.illegal = !legal;
`endif
  end

  // ---------------------------------------------------------------------------
  // Main + skid buffer
  // ---------------------------------------------------------------------------
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     accept;
  logic     drain;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // in_ready is low whenever skid holds data, so skid and accept never collide here
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_alu_op = main_q.op;
  assign out_in0    = main_q.in0;
  assign out_in1    = main_q.in1;
  assign out_rd     = main_q.rd;
  assign out_we     = main_q.we;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus backpressure, flush and reset
// sequences.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_in0;
  logic [31:0] out_in1;
  logic [4:0]  out_rd;
  logic        out_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        out_illegal;
`endif

  alu_issue_stage #(
    .N_BITS  (32),
    .ALU_OP_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu_op (out_alu_op),
    .out_in0    (out_in0),
    .out_in1    (out_in1),
    .out_rd     (out_rd),
    .out_we     (out_we)
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NumVec = 15;
  localparam logic [31:0] InstrAdd = 32'h002081B3;
  localparam logic [31:0] InstrSub = 32'h402081B3;

  vec_t vecs[NumVec];
  int   n_vec;
  int   n_miss;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [3:0] op, input logic [31:0] in0,
                              input logic [31:0] in1, input logic [4:0] rd,
                              input logic we, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.op = op; v.in0 = in0; v.in1 = in1; v.rd = rd; v.we = we; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] rs1);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_rs1_data = rs1;
    in_rs2_data = 32'd7;
    in_pc       = 32'h100;
  endtask

  logic [31:0] rx[$];
  int          acc;
  int          got;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    vecs[0]  = mk(32'h002081B3, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    vecs[1]  = mk(32'h402081B3, 32'h100, 32'd5, 32'd7, 4'b0001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    vecs[2]  = mk(32'h40435293, 32'h100, 32'h80000000, 32'd7, 4'b1011, 32'h80000000, 32'd4,
                  5'd5, 1'b1, 1'b0);
    vecs[3]  = mk(32'hFFF00093, 32'h100, 32'd0, 32'd7, 4'b0000, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1,
                  1'b0);
    vecs[4]  = mk(32'h12345137, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd0, 32'h12345000, 5'd2, 1'b1,
                  1'b0);
    vecs[5]  = mk(32'h00001217, 32'h100, 32'd5, 32'd7, 4'b0000, 32'h100, 32'h1000, 5'd4, 1'b1,
                  1'b0);
    vecs[6]  = mk(32'h00000073, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    vecs[7]  = mk(32'h00208033, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);
    vecs[8]  = mk(32'h4020D1B3, 32'h100, 32'd5, 32'd7, 4'b1011, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    vecs[9]  = mk(32'h402091B3, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    vecs[10] = mk(32'h40209093, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    vecs[11] = mk(32'hFFB0A313, 32'h100, 32'd5, 32'd7, 4'b0100, 32'd5, 32'hFFFFFFFB, 5'd6, 1'b1,
                  1'b0);
    vecs[12] = mk(32'h40008093, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd5, 32'h400, 5'd1, 1'b1, 1'b0);
    vecs[13] = mk(32'h022081B3, 32'h100, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    vecs[14] = mk(32'h01F35293, 32'h100, 32'd5, 32'd7, 4'b1010, 32'd5, 32'h1F, 5'd5, 1'b1, 1'b0);

    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = 32'h0;
    in_pc       = 32'h0;
    in_rs1_data = 32'h0;
    in_rs2_data = 32'h0;
    out_ready   = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst alu_op", 32'(out_alu_op), 32'd0);
    check("rst in0", out_in0, 32'd0);
    check("rst in1", out_in1, 32'd0);
    check("rst we", 32'(out_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table, presented back to back at full throughput
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_instr    = vecs[i].instr;
      in_pc       = vecs[i].pc;
      in_rs1_data = vecs[i].rs1;
      in_rs2_data = vecs[i].rs2;
      out_ready   = 1'b1;
      @(posedge clk); #1;
      check($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d alu_op", i), 32'(out_alu_op), 32'(vecs[i].op));
      check($sformatf("v%0d in0", i), out_in0, vecs[i].in0);
      check($sformatf("v%0d in1", i), out_in1, vecs[i].in1);
      check($sformatf("v%0d rd", i), 32'(out_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d we", i), 32'(out_we), 32'(vecs[i].we));
`ifdef ALU_ISSUE_ILLEGAL_EN
      check($sformatf("v%0d illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
`endif
    end
    idle_cycles(2);
    check("drained valid", 32'(out_valid), 32'd0);

    // Backpressure: 4 ops, out_ready low for the first 3 cycles
    acc = 0;
    got = 0;
    rx.delete();
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        check("bp in_ready low", 32'(in_ready), 32'd0);
        check("bp accepted", 32'(acc), 32'd2);
      end
      out_ready = (cyc >= 3);
      if (acc < 4) present(InstrAdd, 32'h100 + 32'(acc));
      else in_valid = 1'b0;
      if (out_valid && out_ready) begin
        rx.push_back(out_in0);
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    check("bp count", 32'(got), 32'd4);
    for (int k = 0; k < rx.size(); k++) check($sformatf("bp order%0d", k), rx[k], 32'h100 + 32'(k));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp no dup", 32'(out_valid), 32'd0);

    // Flush with skid full
    idle_cycles(1);
    out_ready = 1'b0;
    present(InstrAdd, 32'h11);
    @(negedge clk);
    present(InstrAdd, 32'h22);
    @(negedge clk);
    check("fl skid full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    present(InstrAdd, 32'h33);
    @(posedge clk); #1;
    check("fl out_valid", 32'(out_valid), 32'd0);
    check("fl in_ready", 32'(in_ready), 32'd1);

    // Flush drops an input presented in the same cycle, even with in_ready high
    idle_cycles(1);
    out_ready = 1'b0;
    present(InstrAdd, 32'h44);
    @(negedge clk);
    check("fl2 in_ready", 32'(in_ready), 32'd1);
    flush = 1'b1;
    present(InstrAdd, 32'h55);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("fl2 dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    idle_cycles(1);
    out_ready = 1'b0;
    present(InstrSub, 32'h66);
    @(negedge clk);
    present(InstrSub, 32'h77);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar out_valid", 32'(out_valid), 32'd0);
    check("ar in_ready", 32'(in_ready), 32'd1);
    check("ar alu_op", 32'(out_alu_op), 32'd0);
    check("ar in0", out_in0, 32'd0);
    check("ar in1", out_in1, 32'd0);
    check("ar rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("ar post valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
